// File: rtl/rv32i_trace_pkg.sv
// Shared constants for the rv32i writeback trace buffer: FSM states, capture modes
// and trace-entry field widths.
package rv32i_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POST    = 2'd2,
      ST_FROZEN  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_STREAM = 2'd0;
   localparam logic [1:0] MODE_PC     = 2'd1;
   localparam logic [1:0] MODE_RD     = 2'd2;
   localparam logic [1:0] MODE_RSVD   = 2'd3;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_RA_W   = 5;
   localparam int unsigned DEF_DEPTH  = 16;
   localparam int unsigned DEF_CYC_W  = 16;

   // Stored entry is {pc, rd, data, stamp}.
   function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned ra_w,
                                           input int unsigned cyc_w);
      return 2 * data_w + ra_w + cyc_w;
   endfunction

endpackage

// File: rtl/rv32i_trace_ram.sv
// Trace storage: one write port, one registered read port with write-to-read
// forwarding so the head register always shows the post-write contents.
module rv32i_trace_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 85
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         rdata <= '0;
      else if (we && (waddr == raddr)) rdata <= wdata;
      else                             rdata <= mem[raddr];
   end

endmodule

// File: rtl/rv32i_wb_trace_buf.sv
// Retirement-trace buffer on the rv32i writeback port: stream FIFO or
// PC/rd-triggered circular capture with post-trigger depth and valid/ready readout.
module rv32i_wb_trace_buf
   import rv32i_trace_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RA_W   = DEF_RA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned CYC_W  = DEF_CYC_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     arm_i,
   input  logic [1:0]               mode_i,
   input  logic [DATA_W-1:0]        trig_pc_i,
   input  logic [RA_W-1:0]          trig_rd_i,
   input  logic [$clog2(DEPTH):0]   post_cnt_i,
   input  logic                     wb_regwrite_i,
   input  logic [RA_W-1:0]          wb_rd_addr_i,
   input  logic [DATA_W-1:0]        wb_wdata_i,
   input  logic [DATA_W-1:0]        wb_pc_i,
   input  logic                     rd_ready_i,
   output logic                     rd_valid_o,
   output logic [DATA_W-1:0]        rd_pc_o,
   output logic [RA_W-1:0]          rd_addr_o,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic [CYC_W-1:0]         rd_cyc_o,
   output logic [1:0]               state_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = entry_w(DATA_W, RA_W, CYC_W);

   state_t             state_q, state_n;
   logic [1:0]         mode_q, mode_n;
   logic [CYC_W-1:0]   cyc_q;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
   logic [CNT_W-1:0]   count_q, count_n, post_left_q, post_left_n, post_clamp;
   logic               overflow_q, overflow_n, rd_valid_n, wr_en;
   logic               ev, full, pop, circ, hit, trig;
   logic [ENTRY_W-1:0] rdata;

   assign ev         = wb_regwrite_i && (wb_rd_addr_i != '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign pop        = rd_valid_o && rd_ready_i;
   assign circ       = ((state_q == ST_CAPTURE) && (mode_q != MODE_STREAM)) || (state_q == ST_POST);
   assign hit        = (mode_q == MODE_PC) ? (wb_pc_i == trig_pc_i) : (wb_rd_addr_i == trig_rd_i);
   assign trig       = ev && hit && (state_q == ST_CAPTURE) && (mode_q != MODE_STREAM);
   assign post_clamp = (post_cnt_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : post_cnt_i;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_n;
   end

   // Next-state logic; clear wins over everything else
   always_comb begin
      state_n = state_q;
      if (clear_i) begin
         state_n = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (arm_i) state_n = ST_CAPTURE;
            ST_CAPTURE: if (trig)  state_n = (post_clamp <= CNT_W'(1)) ? ST_FROZEN : ST_POST;
            ST_POST:    if (ev && (post_left_q <= CNT_W'(1))) state_n = ST_FROZEN;
            ST_FROZEN:  if ((count_q == '0) || (pop && (count_q == CNT_W'(1)))) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
         endcase
      end
   end

   // Datapath control: write enable, pointer/count/flag updates
   always_comb begin
      wr_en       = 1'b0;
      wr_ptr_n    = wr_ptr_q;
      rd_ptr_n    = rd_ptr_q;
      count_n     = count_q;
      overflow_n  = overflow_q;
      post_left_n = post_left_q;
      mode_n      = mode_q;
      if (clear_i) begin
         wr_ptr_n    = '0;
         rd_ptr_n    = '0;
         count_n     = '0;
         overflow_n  = 1'b0;
         post_left_n = '0;
      end else begin
         case (state_q)
            ST_IDLE: if (arm_i) begin
               wr_ptr_n   = '0;
               rd_ptr_n   = '0;
               count_n    = '0;
               overflow_n = 1'b0;
               mode_n     = (mode_i == MODE_RSVD) ? MODE_STREAM : mode_i;
            end
            ST_CAPTURE, ST_POST: begin
               if (!circ) begin
                  if (pop) rd_ptr_n = rd_ptr_q + PTR_W'(1);
                  if (ev && (!full || pop)) begin
                     wr_en    = 1'b1;
                     wr_ptr_n = wr_ptr_q + PTR_W'(1);
                  end else if (ev) begin
                     overflow_n = 1'b1;
                  end
                  count_n = count_q + CNT_W'(wr_en) - CNT_W'(pop);
               end else if (ev) begin
                  // Circular capture: a full buffer drops its oldest entry
                  wr_en    = 1'b1;
                  wr_ptr_n = wr_ptr_q + PTR_W'(1);
                  if (full) rd_ptr_n = rd_ptr_q + PTR_W'(1);
                  else      count_n  = count_q + CNT_W'(1);
                  if (trig)                    post_left_n = post_clamp - CNT_W'(1);
                  else if (state_q == ST_POST) post_left_n = post_left_q - CNT_W'(1);
               end
            end
            ST_FROZEN: if (pop) begin
               rd_ptr_n = rd_ptr_q + PTR_W'(1);
               count_n  = count_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
      rd_valid_n = (count_n != '0) &&
                   (((state_n == ST_CAPTURE) && (mode_n == MODE_STREAM)) || (state_n == ST_FROZEN));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_q       <= '0;
         mode_q      <= MODE_STREAM;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         post_left_q <= '0;
         overflow_q  <= 1'b0;
         rd_valid_o  <= 1'b0;
      end else begin
         cyc_q       <= cyc_q + CYC_W'(1);
         mode_q      <= mode_n;
         wr_ptr_q    <= wr_ptr_n;
         rd_ptr_q    <= rd_ptr_n;
         count_q     <= count_n;
         post_left_q <= post_left_n;
         overflow_q  <= overflow_n;
         rd_valid_o  <= rd_valid_n;
      end
   end

   rv32i_trace_ram #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_ram (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata ({wb_pc_i, wb_rd_addr_i, wb_wdata_i, cyc_q}),
      .raddr (rd_ptr_n),
      .rdata (rdata)
   );

   assign {rd_pc_o, rd_addr_o, rd_data_o, rd_cyc_o} = rdata;
   assign state_o    = state_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule
